// File: rtl/cfg_timeout_pkg.sv
// rtl/cfg_timeout_pkg.sv - shared types and constants for the config-space access timeout controller
package cfg_timeout_pkg;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_RSP    = 2'd1,
        S_TIMEOUT_RSP = 2'd2,
        S_DRAIN       = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         STAT_W      = 16;

    function automatic int max_u(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cfg_access_timeout_ctrl_if.sv
// rtl/cfg_access_timeout_ctrl_if.sv - HPS/CS handshake and response-mux bundle
interface cfg_access_timeout_ctrl_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 2
);
    logic                  hps_read_i;
    logic                  hps_write_i;
    logic [ADDR_WIDTH-1:0] hps_address_i;
    logic                  hps_waitrequest_o;
    logic                  cs_read_o;
    logic                  cs_write_o;
    logic                  cs_waitrequest_i;
    logic                  cs_readdatavalid_i;
    logic                  cs_writerespvalid_i;
    logic                  config_readdatavalid_o;
    logic                  config_writerespvalid_o;
    logic [DATA_WIDTH-1:0] config_readdata_o;
    logic [RESP_WIDTH-1:0] config_resp_o;
    logic                  select_o;

    modport slave (
        input  hps_read_i, hps_write_i, hps_address_i,
        input  cs_waitrequest_i, cs_readdatavalid_i, cs_writerespvalid_i,
        output hps_waitrequest_o, cs_read_o, cs_write_o,
        output config_readdatavalid_o, config_writerespvalid_o,
        output config_readdata_o, config_resp_o, select_o
    );

    modport master (
        output hps_read_i, hps_write_i, hps_address_i,
        output cs_waitrequest_i, cs_readdatavalid_i, cs_writerespvalid_i,
        input  hps_waitrequest_o, cs_read_o, cs_write_o,
        input  config_readdatavalid_o, config_writerespvalid_o,
        input  config_readdata_o, config_resp_o, select_o
    );
endinterface

// File: rtl/cfg_timeout_cnt.sv
// rtl/cfg_timeout_cnt.sv - clearable enable-gated up-counter that parks at its terminal value
module cfg_timeout_cnt #(
    parameter int W = 13
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_term
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != i_term)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_term = (r_cnt == i_term);
endmodule

// File: rtl/cfg_access_timeout_ctrl.sv
// rtl/cfg_access_timeout_ctrl.sv - one-at-a-time CS access sequencer with synthetic error completion on timeout
module cfg_access_timeout_ctrl
    import cfg_timeout_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 14,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    RESP_WIDTH     = 2,
    parameter int                    TIMEOUT_CYCLES = 4096,
    parameter int                    DRAIN_CYCLES   = 4096,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = '1,
    parameter logic [RESP_WIDTH-1:0] TIMEOUT_RESP   = RESP_WIDTH'(RESP_SLVERR)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  timeout_en_i,
    cfg_access_timeout_ctrl_if.slave bus,
    output logic                  timeout_pulse_o,
    output logic [STAT_W-1:0]     timeout_count_o,
    output logic [ADDR_WIDTH-1:0] last_timeout_addr_o
);
    localparam int CNT_W = $clog2(max_u(TIMEOUT_CYCLES, DRAIN_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DR_TERM = CNT_W'(DRAIN_CYCLES - 1);

    state_e                r_state;
    logic                  r_is_write;
    logic                  r_no_drain;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_select;
    logic                  r_cfg_rvalid;
    logic                  r_cfg_wvalid;
    logic [DATA_WIDTH-1:0] r_cfg_rdata;
    logic [RESP_WIDTH-1:0] r_cfg_resp;
    logic                  r_pulse;
    logic [STAT_W-1:0]     r_count;
    logic [ADDR_WIDTH-1:0] r_last_addr;

    logic                  w_strobe, w_idle, w_stall, w_accept, w_match;
    logic                  w_cnt_term, w_cnt_fire, w_cnt_clr;
    logic                  w_stall_to, w_wait_to, w_enter_to, w_wait_done, w_drain_done;
    logic                  w_to_is_write;
    logic [ADDR_WIDTH-1:0] w_to_addr;
    logic [CNT_W-1:0]      w_term_val;

    assign w_idle     = (r_state == S_IDLE);
    assign w_strobe   = bus.hps_read_i | bus.hps_write_i;
    assign w_stall    = w_idle && w_strobe && bus.cs_waitrequest_i;
    assign w_accept   = w_idle && w_strobe && !bus.cs_waitrequest_i;
    assign w_match    = r_is_write ? bus.cs_writerespvalid_i : bus.cs_readdatavalid_i;
    assign w_cnt_fire = timeout_en_i && w_cnt_term;

    assign w_stall_to   = w_stall && w_cnt_fire;
    assign w_wait_done  = (r_state == S_WAIT_RSP) && w_match;
    assign w_wait_to    = (r_state == S_WAIT_RSP) && !w_match && w_cnt_fire;
    assign w_drain_done = (r_state == S_DRAIN) && (w_match || w_cnt_fire);
    assign w_enter_to   = w_stall_to || w_wait_to;

    // A stalled access has not been latched yet, so its attributes come straight off the bus.
    assign w_to_is_write = w_idle ? bus.hps_write_i   : r_is_write;
    assign w_to_addr     = w_idle ? bus.hps_address_i : r_addr;

    assign w_term_val = (r_state == S_DRAIN) ? DR_TERM : TO_TERM;
    assign w_cnt_clr  = (w_idle && !w_stall) || w_stall_to || w_wait_done || w_wait_to
                      || (r_state == S_TIMEOUT_RSP) || w_drain_done;

    cfg_timeout_cnt #(.W(CNT_W)) u_cnt (
        .i_clk   (clk_i),
        .i_rst_n (rstn_i),
        .i_clr   (w_cnt_clr),
        .i_en    (timeout_en_i),
        .i_term  (w_term_val),
        .o_term  (w_cnt_term)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= S_IDLE;
            r_is_write   <= 1'b0;
            r_no_drain   <= 1'b0;
            r_addr       <= '0;
            r_select     <= 1'b0;
            r_cfg_rvalid <= 1'b0;
            r_cfg_wvalid <= 1'b0;
            r_cfg_rdata  <= '0;
            r_cfg_resp   <= '0;
            r_pulse      <= 1'b0;
            r_count      <= '0;
            r_last_addr  <= '0;
        end else begin
            r_pulse      <= 1'b0;
            r_cfg_rvalid <= 1'b0;
            r_cfg_wvalid <= 1'b0;
            r_cfg_rdata  <= '0;
            r_cfg_resp   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept || w_stall_to) begin
                        r_addr     <= bus.hps_address_i;
                        r_is_write <= bus.hps_write_i;
                        r_no_drain <= w_stall_to;
                        r_state    <= w_stall_to ? S_TIMEOUT_RSP : S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (w_match) begin
                        r_state <= S_IDLE;
                    end else if (w_cnt_fire) begin
                        r_state <= S_TIMEOUT_RSP;
                    end
                end
                S_TIMEOUT_RSP: begin
                    r_state  <= r_no_drain ? S_IDLE : S_DRAIN;
                    r_select <= !r_no_drain;
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state  <= S_IDLE;
                        r_select <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_enter_to) begin
                r_select     <= 1'b1;
                r_cfg_rvalid <= !w_to_is_write;
                r_cfg_wvalid <= w_to_is_write;
                r_cfg_rdata  <= TIMEOUT_DATA;
                r_cfg_resp   <= TIMEOUT_RESP;
                r_pulse      <= 1'b1;
                r_count      <= (r_count == {STAT_W{1'b1}}) ? r_count : r_count + STAT_W'(1);
                r_last_addr  <= w_to_addr;
            end
        end
    end

    assign bus.cs_read_o         = w_idle && !w_stall_to && bus.hps_read_i;
    assign bus.cs_write_o        = w_idle && !w_stall_to && bus.hps_write_i;
    assign bus.hps_waitrequest_o = w_idle ? (bus.cs_waitrequest_i && !w_stall_to) : 1'b1;

    assign bus.select_o                = r_select;
    assign bus.config_readdatavalid_o  = r_cfg_rvalid;
    assign bus.config_writerespvalid_o = r_cfg_wvalid;
    assign bus.config_readdata_o       = r_cfg_rdata;
    assign bus.config_resp_o           = r_cfg_resp;
    assign timeout_pulse_o             = r_pulse;
    assign timeout_count_o             = r_count;
    assign last_timeout_addr_o         = r_last_addr;
endmodule

// File: tb/tb_cfg_access_timeout_ctrl.sv
// tb/tb_cfg_access_timeout_ctrl.sv - scoreboard bench for cfg_access_timeout_ctrl
module tb_cfg_access_timeout_ctrl;
    localparam int TO = 16;
    localparam int DR = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b1;
    logic        pulse;
    logic [15:0] count;
    logic [13:0] last_addr;

    cfg_access_timeout_ctrl_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .RESP_WIDTH(2)) bus ();

    cfg_access_timeout_ctrl #(
        .ADDR_WIDTH(14), .DATA_WIDTH(32), .RESP_WIDTH(2),
        .TIMEOUT_CYCLES(TO), .DRAIN_CYCLES(DR),
        .TIMEOUT_DATA(32'hFFFF_FFFF), .TIMEOUT_RESP(2'b10)
    ) dut (
        .clk_i               (clk),
        .rstn_i              (rstn),
        .timeout_en_i        (en),
        .bus                 (bus),
        .timeout_pulse_o     (pulse),
        .timeout_count_o     (count),
        .last_timeout_addr_o (last_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [13:0] a;
        int          cyc;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   model_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every synthetic completion must match the oldest predicted timeout.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.config_readdatavalid_o || bus.config_writerespvalid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_cpl", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("cpl_cycle", cyc, e.cyc);
                    chk("cpl_rvalid", bus.config_readdatavalid_o, !e.w);
                    chk("cpl_wvalid", bus.config_writerespvalid_o, e.w);
                    chk("cpl_data", bus.config_readdata_o, 32'hFFFF_FFFF);
                    chk("cpl_resp", bus.config_resp_o, 2'b10);
                    chk("cpl_select", bus.select_o, 1);
                    chk("cpl_pulse", pulse, 1);
                    chk("cpl_addr", last_addr, e.a);
                    chk("cpl_count", count, e.cnt[15:0]);
                end
            end else if (pulse) begin
                chk("stray_pulse", pulse, 0);
            end
        end
    end

    function automatic bit times_out(input int d);
        return en && (d == 0 || d > TO);
    endfunction

    task automatic start_access(input bit w, input logic [13:0] a, output int acc);
        @(posedge clk); #1;
        bus.hps_read_i       = !w;
        bus.hps_write_i      = w;
        bus.hps_address_i    = a;
        bus.cs_waitrequest_i = 1'b0;
        @(negedge clk);
        chk("pass_strobe", w ? bus.cs_write_o : bus.cs_read_o, 1);
        chk("pass_wait", bus.hps_waitrequest_o, 0);
        @(posedge clk); #1;
        acc = cyc;
        bus.hps_read_i  = 1'b0;
        bus.hps_write_i = 1'b0;
    endtask

    // d = cycles after accept at which CS completes; 0 = never.
    task automatic do_access(input bit w, input logic [13:0] a, input int d);
        int acc;
        bit to;
        start_access(w, a, acc);
        to = times_out(d);
        if (to) begin
            model_count++;
            q.push_back('{w: w, a: a, cyc: acc + TO, cnt: model_count});
        end
        if (d != 0) begin
            repeat (d - 1) @(posedge clk);
            #1;
            if (w) bus.cs_writerespvalid_i = 1'b1;
            else   bus.cs_readdatavalid_i  = 1'b1;
            @(negedge clk);
            chk("cpl_masked", bus.select_o, to);
            chk("gated_strobe", bus.cs_read_o | bus.cs_write_o, 0);
            @(posedge clk); #1;
            bus.cs_writerespvalid_i = 1'b0;
            bus.cs_readdatavalid_i  = 1'b0;
        end
        while (cyc < acc + TO + DR + 6) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic stall_read(input logic [13:0] a);
        int p;
        @(posedge clk); #1;
        p = cyc;
        bus.hps_read_i       = 1'b1;
        bus.hps_address_i    = a;
        bus.cs_waitrequest_i = 1'b1;
        model_count++;
        q.push_back('{w: 1'b0, a: a, cyc: p + TO, cnt: model_count});
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk("stall_wait", bus.hps_waitrequest_o, (k < TO - 1));
            chk("stall_strobe", bus.cs_read_o, (k < TO - 1));
        end
        @(posedge clk); #1;
        bus.hps_read_i       = 1'b0;
        bus.cs_waitrequest_i = 1'b0;
    endtask

    initial begin
        int acc;
        bus.hps_read_i = 0; bus.hps_write_i = 0; bus.hps_address_i = '0;
        bus.cs_waitrequest_i = 0; bus.cs_readdatavalid_i = 0; bus.cs_writerespvalid_i = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_select", bus.select_o, 0);
        chk("rst_valids", {bus.config_readdatavalid_o, bus.config_writerespvalid_o, pulse}, 0);
        chk("rst_data_resp", {bus.config_readdata_o, bus.config_resp_o}, 0);
        chk("rst_status", {count, last_addr}, 0);
        rstn = 1'b1;

        do_access(1'b0, 14'h0042, 5);
        do_access(1'b0, 14'h0123, 0);
        do_access(1'b1, 14'h0200, TO + 3);
        do_access(1'b1, 14'h0201, 3);
        stall_read(14'h0333);
        do_access(1'b0, 14'h0334, 2);
        do_access(1'b0, 14'h0400, TO);

        for (int i = 0; i < 20; i++) begin
            do_access(1'($urandom_range(0, 1)), 14'($urandom), int'($urandom_range(0, TO + DR + 1)));
        end

        start_access(1'b1, 14'h0555, acc);
        model_count++;
        q.push_back('{w: 1'b1, a: 14'h0555, cyc: acc + TO, cnt: model_count});
        while (cyc < acc + TO + 3) @(posedge clk);
        #2;
        chk("drain_select", bus.select_o, 1);
        rstn = 1'b0;
        #1;
        model_count = 0;
        chk("rstmid_select", bus.select_o, 0);
        chk("rstmid_count", count, 0);
        chk("rstmid_addr", last_addr, 0);
        @(negedge clk);
        rstn = 1'b1;

        en = 1'b0;
        do_access(1'b0, 14'h0666, 100);
        en = 1'b1;
        do_access(1'b1, 14'h0777, 0);

        repeat (5) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end
endmodule
